// File: rtl/multi_release_unit.sv
// multi_release_unit
// Holds up to NUM_ENTRIES outstanding cache-block releases or probe acks.
// Each entry sends its message on TileLink channel C. A voluntary Release then
// waits for a ReleaseAck on channel D, while a ProbeAck completes as soon as
// its last beat fires.
//
// Ports:
//   clock, reset                 sole clock; asynchronous active-low reset
//   io_req_*                     request handshake and payload (data beat 0 = [255:0])
//   io_finish, io_finish_id      one-cycle completion pulse and the entry that completed
//   io_mem_release_*             channel C handshake and message fields (one 256-bit beat)
//   io_mem_grant_*               channel D handshake (ready tied high) and source id
//
// Optional feature macro: MULTI_RELEASE_UNIT_ADDR_CHECK_EN
//   When defined, requests are blocked while any busy entry holds the same
//   64-byte block (addr[35:6]). When undefined, no address compare is made.
module multi_release_unit #(
    parameter int NUM_ENTRIES = 2,
    parameter int BEATS       = 2,
    parameter int SRC_W       = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_req_valid,
    output logic                   io_req_ready,
    input  logic [35:0]            io_req_bits_addr,
    input  logic [2:0]             io_req_bits_param,
    input  logic                   io_req_bits_voluntary,
    input  logic                   io_req_bits_hasData,
    input  logic                   io_req_bits_dirty,
    input  logic [256*BEATS-1:0]   io_req_bits_data,
    output logic                   io_finish,
    output logic [SRC_W-1:0]       io_finish_id,
    output logic                   io_mem_release_valid,
    input  logic                   io_mem_release_ready,
    output logic [2:0]             io_mem_release_bits_opcode,
    output logic [2:0]             io_mem_release_bits_param,
    output logic [2:0]             io_mem_release_bits_size,
    output logic [SRC_W-1:0]       io_mem_release_bits_source,
    output logic [35:0]            io_mem_release_bits_address,
    output logic                   io_mem_release_bits_echo_blockisdirty,
    output logic [255:0]           io_mem_release_bits_data,
    input  logic                   io_mem_grant_valid,
    output logic                   io_mem_grant_ready,
    input  logic [SRC_W-1:0]       io_mem_grant_bits_source
);
    localparam int BEAT_W = 256;
    localparam int DATA_W = BEAT_W * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e                 r_state [NUM_ENTRIES];
    logic [CNT_W-1:0]       r_cnt   [NUM_ENTRIES];
    logic [35:0]            r_addr  [NUM_ENTRIES];
    logic [2:0]             r_param [NUM_ENTRIES];
    logic [DATA_W-1:0]      r_data  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_vol;
    logic [NUM_ENTRIES-1:0] r_has;
    logic [NUM_ENTRIES-1:0] r_dirty;
    // A ProbeAck whose last beat fired while a ReleaseAck took io_finish; it
    // stays in SEND, out of arbitration, until its own pulse is issued.
    logic [NUM_ENTRIES-1:0] r_done;
    logic [SRC_W-1:0]       r_rr;
    logic                   r_lock;
    logic [SRC_W-1:0]       r_lock_id;

    logic [NUM_ENTRIES-1:0] w_idle;
    logic [NUM_ENTRIES-1:0] w_req;
    logic [NUM_ENTRIES-1:0] w_g_vec;
    logic                   w_conflict;
    logic [SRC_W-1:0]       w_alloc_id;
    logic                   w_req_fire;
    logic                   w_win_hit;
    logic [SRC_W-1:0]       w_win_id;
    logic                   w_c_last;
    logic                   w_c_fire;
    logic                   w_sel_vol;
    logic                   w_g_hit;
    logic [SRC_W-1:0]       w_g_id;
    logic                   w_done_hit;
    logic [SRC_W-1:0]       w_done_id;
    logic                   w_pa_done;

    // Entry status vectors, lowest idle entry, grant match and same-block compare
    always_comb begin
        w_idle     = '0;
        w_req      = '0;
        w_g_vec    = '0;
        w_conflict = 1'b0;
        w_alloc_id = '0;
        w_g_id     = '0;
        w_done_id  = '0;
        w_done_hit = |r_done;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            w_idle[i]  = (r_state[i] == S_IDLE);
            w_req[i]   = (r_state[i] == S_SEND) && !r_done[i];
            w_g_vec[i] = io_mem_grant_valid && (io_mem_grant_bits_source == SRC_W'(i))
                         && (r_state[i] == S_WAIT);
            w_alloc_id = w_idle[i]  ? SRC_W'(i) : w_alloc_id;
            w_g_id     = w_g_vec[i] ? SRC_W'(i) : w_g_id;
            w_done_id  = r_done[i]  ? SRC_W'(i) : w_done_id;
`ifdef MULTI_RELEASE_UNIT_ADDR_CHECK_EN
            w_conflict = w_conflict | (!w_idle[i] && (r_addr[i][35:6] == io_req_bits_addr[35:6]));
`endif
        end
        w_g_hit = |w_g_vec;
    end

    assign io_req_ready       = (|w_idle) && !w_conflict;
    assign w_req_fire         = io_req_valid && io_req_ready;
    assign io_mem_grant_ready = 1'b1;

    // Channel C winner: the locked entry, else the first requester at or after the RR pointer
    always_comb begin
        int best_d;
        int d;
        logic take;
        best_d    = NUM_ENTRIES;
        d         = 0;
        take      = 1'b0;
        w_win_hit = 1'b0;
        w_win_id  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            d         = (i + NUM_ENTRIES - int'(r_rr)) % NUM_ENTRIES;
            take      = w_req[i] && (d < best_d);
            best_d    = take ? d : best_d;
            w_win_id  = take ? SRC_W'(i) : w_win_id;
            w_win_hit = w_win_hit | take;
        end
        if (r_lock) begin
            w_win_hit = 1'b1;
            w_win_id  = r_lock_id;
        end else begin
            w_win_hit = w_win_hit;
        end
    end

    // Channel C field mux from the winning entry; valid is purely state-derived
    always_comb begin
        logic sel;
        sel                                   = 1'b0;
        io_mem_release_valid                  = w_win_hit;
        io_mem_release_bits_opcode            = 3'd0;
        io_mem_release_bits_param             = 3'd0;
        io_mem_release_bits_size              = 3'd6;
        io_mem_release_bits_source            = w_win_id;
        io_mem_release_bits_address           = 36'd0;
        io_mem_release_bits_echo_blockisdirty = 1'b0;
        io_mem_release_bits_data              = '0;
        w_c_last                              = 1'b0;
        w_sel_vol                             = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel = w_win_hit && (w_win_id == SRC_W'(i));
            io_mem_release_bits_opcode  |= {3{sel}} & {1'b1, r_vol[i], r_has[i]};
            io_mem_release_bits_param   |= {3{sel}} & r_param[i];
            io_mem_release_bits_address |= {36{sel}} & r_addr[i];
            io_mem_release_bits_echo_blockisdirty |= sel & r_dirty[i];
            w_sel_vol |= sel & r_vol[i];
            w_c_last  |= sel & (r_has[i] ? (r_cnt[i] == CNT_W'(BEATS - 1)) : 1'b1);
            for (int b = 0; b < BEATS; b++) begin
                io_mem_release_bits_data |= {BEAT_W{sel && r_has[i] && (r_cnt[i] == CNT_W'(b))}}
                                            & r_data[i][b*BEAT_W +: BEAT_W];
            end
        end
    end

    assign w_c_fire  = io_mem_release_valid && io_mem_release_ready;
    assign w_pa_done = w_c_fire && w_c_last && !w_sel_vol;

    // Completion pulse: ReleaseAck first, then a deferred ProbeAck, then a ProbeAck finishing now
    always_comb begin
        if (w_g_hit) begin
            io_finish    = 1'b1;
            io_finish_id = w_g_id;
        end else if (w_done_hit) begin
            io_finish    = 1'b1;
            io_finish_id = w_done_id;
        end else if (w_pa_done) begin
            io_finish    = 1'b1;
            io_finish_id = w_win_id;
        end else begin
            io_finish    = 1'b0;
            io_finish_id = '0;
        end
    end

    // Per-entry FSM: capture on allocation, beat stepping, completion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_addr[i]  <= 36'd0;
                r_param[i] <= 3'd0;
                r_data[i]  <= '0;
            end
            r_vol   <= '0;
            r_has   <= '0;
            r_dirty <= '0;
            r_done  <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                case (r_state[i])
                    S_IDLE: begin
                        if (w_req_fire && (w_alloc_id == SRC_W'(i))) begin
                            r_state[i] <= S_SEND;
                            r_cnt[i]   <= '0;
                            r_done[i]  <= 1'b0;
                            r_addr[i]  <= io_req_bits_addr;
                            r_param[i] <= io_req_bits_param;
                            r_data[i]  <= io_req_bits_data;
                            r_vol[i]   <= io_req_bits_voluntary;
                            r_has[i]   <= io_req_bits_hasData;
                            r_dirty[i] <= io_req_bits_dirty;
                        end else begin
                            r_state[i] <= S_IDLE;
                        end
                    end
                    S_SEND: begin
                        if (r_done[i]) begin
                            // Deferred ProbeAck retires only in a cycle it owns io_finish
                            if (!w_g_hit && (w_done_id == SRC_W'(i))) begin
                                r_state[i] <= S_IDLE;
                                r_done[i]  <= 1'b0;
                            end else begin
                                r_state[i] <= S_SEND;
                            end
                        end else if (w_c_fire && (w_win_id == SRC_W'(i))) begin
                            if (w_c_last) begin
                                r_cnt[i] <= '0;
                                if (r_vol[i]) begin
                                    r_state[i] <= S_WAIT;
                                end else if (!w_g_hit && !w_done_hit) begin
                                    r_state[i] <= S_IDLE;
                                end else begin
                                    r_done[i] <= 1'b1;
                                end
                            end else begin
                                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                            end
                        end else begin
                            r_state[i] <= S_SEND;
                        end
                    end
                    S_WAIT: begin
                        if (w_g_vec[i]) begin
                            r_state[i] <= S_IDLE;
                        end else begin
                            r_state[i] <= S_WAIT;
                        end
                    end
                    default: begin
                        r_state[i] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Round-robin pointer and channel lock. Once an entry is presented it keeps
    // the channel until its last beat fires, so fields never change under a stall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr      <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_c_fire && w_c_last) begin
            r_lock <= 1'b0;
            r_rr   <= (w_win_id == SRC_W'(NUM_ENTRIES - 1)) ? '0 : (w_win_id + SRC_W'(1));
        end else if (w_win_hit) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_win_id;
        end else begin
            r_lock <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multi_release_unit.sv
module tb_multi_release_unit;
    localparam int NE = 2;
    localparam int BT = 2;
    localparam int SW = 2;
    localparam int ST_FREE = 0;
    localparam int ST_SEND = 1;
    localparam int ST_WAIT = 2;
    localparam int ST_DONE = 3;

    logic            clock;
    logic            reset;
    logic            io_req_valid;
    logic            io_req_ready;
    logic [35:0]     io_req_bits_addr;
    logic [2:0]      io_req_bits_param;
    logic            io_req_bits_voluntary;
    logic            io_req_bits_hasData;
    logic            io_req_bits_dirty;
    logic [511:0]    io_req_bits_data;
    logic            io_finish;
    logic [SW-1:0]   io_finish_id;
    logic            io_mem_release_valid;
    logic            io_mem_release_ready;
    logic [2:0]      io_mem_release_bits_opcode;
    logic [2:0]      io_mem_release_bits_param;
    logic [2:0]      io_mem_release_bits_size;
    logic [SW-1:0]   io_mem_release_bits_source;
    logic [35:0]     io_mem_release_bits_address;
    logic            io_mem_release_bits_echo_blockisdirty;
    logic [255:0]    io_mem_release_bits_data;
    logic            io_mem_grant_valid;
    logic            io_mem_grant_ready;
    logic [SW-1:0]   io_mem_grant_bits_source;

    multi_release_unit #(.NUM_ENTRIES(NE), .BEATS(BT), .SRC_W(SW)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_bits_addr(io_req_bits_addr), .io_req_bits_param(io_req_bits_param),
        .io_req_bits_voluntary(io_req_bits_voluntary), .io_req_bits_hasData(io_req_bits_hasData),
        .io_req_bits_dirty(io_req_bits_dirty), .io_req_bits_data(io_req_bits_data),
        .io_finish(io_finish), .io_finish_id(io_finish_id),
        .io_mem_release_valid(io_mem_release_valid), .io_mem_release_ready(io_mem_release_ready),
        .io_mem_release_bits_opcode(io_mem_release_bits_opcode),
        .io_mem_release_bits_param(io_mem_release_bits_param),
        .io_mem_release_bits_size(io_mem_release_bits_size),
        .io_mem_release_bits_source(io_mem_release_bits_source),
        .io_mem_release_bits_address(io_mem_release_bits_address),
        .io_mem_release_bits_echo_blockisdirty(io_mem_release_bits_echo_blockisdirty),
        .io_mem_release_bits_data(io_mem_release_bits_data),
        .io_mem_grant_valid(io_mem_grant_valid), .io_mem_grant_ready(io_mem_grant_ready),
        .io_mem_grant_bits_source(io_mem_grant_bits_source)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one abstract record per entry
    int           m_st    [NE];
    int           m_beat  [NE];
    logic [35:0]  m_addr  [NE];
    logic [2:0]   m_param [NE];
    logic [511:0] m_data  [NE];
    logic         m_vol   [NE];
    logic         m_has   [NE];
    logic         m_dirty [NE];
    int           m_cur;
    logic         p_valid;
    int           p_src;
    logic [255:0] p_data;
    int           fire_log[$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_st[i]   = ST_FREE;
            m_beat[i] = 0;
        end
        m_cur   = -1;
        p_valid = 1'b0;
    endtask

    function automatic bit all_free();
        bit r = 1'b1;
        for (int i = 0; i < NE; i++) if (m_st[i] != ST_FREE) r = 1'b0;
        return r;
    endfunction

    function automatic logic [511:0] rnd_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic set_req(input logic v, input logic [35:0] a, input logic [2:0] p, input logic vol,
                           input logic has, input logic dty, input logic [511:0] d);
        io_req_valid = v; io_req_bits_addr = a; io_req_bits_param = p;
        io_req_bits_voluntary = vol; io_req_bits_hasData = has; io_req_bits_dirty = dty;
        io_req_bits_data = d;
    endtask

    task automatic settle();
        #1;
    endtask

    // Check all outputs against the model, advance the model, then cross one clock edge
    task automatic tick();
        bit any_send, any_free, conflict, exp_ready, fire, last, g_hit, pa_done, exp_fin, rfire, ok_src;
        int s, gs, exp_id, a_idx, pend;
        logic [255:0] exp_data;
        any_send = 0; any_free = 0; conflict = 0; fire = 0; last = 0; exp_data = '0;
        a_idx = -1; pend = -1;
        for (int i = NE - 1; i >= 0; i--) begin
            if (m_st[i] == ST_SEND) any_send = 1;
            if (m_st[i] == ST_FREE) begin any_free = 1; a_idx = i; end
            else if (m_addr[i][35:6] == io_req_bits_addr[35:6]) conflict = 1;
            if (m_st[i] == ST_DONE) pend = i;
        end
`ifdef MULTI_RELEASE_UNIT_ADDR_CHECK_EN
        exp_ready = any_free && !conflict;
`else
        exp_ready = any_free;
`endif
        chk("req_ready", io_req_ready, exp_ready);
        chk("grant_ready", io_mem_grant_ready, 1'b1);
        chk("rel_valid", io_mem_release_valid, any_send);
        s = int'(io_mem_release_bits_source);
        if (io_mem_release_valid) begin
            ok_src = (s < NE) ? (m_st[s] == ST_SEND) : 1'b0;
            chk("rel_src_sending", ok_src, 1'b1);
            if (s < NE) begin
                if (m_cur >= 0) chk("no_interleave", s, m_cur);
                if (p_valid) chk("hold_src", s, p_src);
                exp_data = m_has[s] ? m_data[s][m_beat[s]*256 +: 256] : 256'd0;
                if (p_valid) chk("hold_data", io_mem_release_bits_data, p_data);
                chk("opcode", io_mem_release_bits_opcode, {1'b1, m_vol[s], m_has[s]});
                chk("param", io_mem_release_bits_param, m_param[s]);
                chk("size", io_mem_release_bits_size, 3'd6);
                chk("address", io_mem_release_bits_address, m_addr[s]);
                chk("dirty", io_mem_release_bits_echo_blockisdirty, m_dirty[s]);
                chk("data", io_mem_release_bits_data, exp_data);
                fire = io_mem_release_ready;
                last = !m_has[s] || (m_beat[s] == BT - 1);
            end
        end
        gs      = int'(io_mem_grant_bits_source);
        g_hit   = (io_mem_grant_valid && gs < NE) ? (m_st[gs] == ST_WAIT) : 1'b0;
        pa_done = fire && last && !m_vol[s];
        exp_fin = 1'b1;
        exp_id  = 0;
        if (g_hit) exp_id = gs;
        else if (pend >= 0) exp_id = pend;
        else if (pa_done) exp_id = s;
        else exp_fin = 1'b0;
        chk("finish", io_finish, exp_fin);
        if (exp_fin) chk("finish_id", io_finish_id, exp_id);
        rfire = io_req_valid && exp_ready;
        if (g_hit) m_st[gs] = ST_FREE;
        else if (pend >= 0) m_st[pend] = ST_FREE;
        if (fire) begin
            fire_log.push_back(s);
            if (last) begin
                m_cur = -1; m_beat[s] = 0;
                if (m_vol[s]) m_st[s] = ST_WAIT;
                else if (!g_hit && pend < 0) m_st[s] = ST_FREE;
                else m_st[s] = ST_DONE;
            end else begin
                m_cur = s; m_beat[s]++;
            end
        end
        p_valid = io_mem_release_valid && !fire && (s < NE);
        p_src   = s;
        p_data  = exp_data;
        if (rfire && a_idx >= 0) begin
            m_st[a_idx]   = ST_SEND;   m_beat[a_idx]  = 0;
            m_addr[a_idx] = io_req_bits_addr;      m_param[a_idx] = io_req_bits_param;
            m_data[a_idx] = io_req_bits_data;      m_vol[a_idx]   = io_req_bits_voluntary;
            m_has[a_idx]  = io_req_bits_hasData;   m_dirty[a_idx] = io_req_bits_dirty;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    // Let every outstanding message finish, granting waiting entries as needed
    task automatic drain();
        io_req_valid = 1'b0;
        io_mem_release_ready = 1'b1;
        for (int k = 0; k < 100 && !all_free(); k++) begin
            io_mem_grant_valid = 1'b0;
            for (int i = NE - 1; i >= 0; i--) begin
                if (m_st[i] == ST_WAIT) begin
                    io_mem_grant_valid = 1'b1;
                    io_mem_grant_bits_source = SW'(i);
                end
            end
            cycle();
        end
        io_mem_grant_valid = 1'b0;
        chk("drain_idle", all_free(), 1'b1);
    endtask

    initial begin
        logic [511:0] d;
        logic [35:0]  a;
        reset = 1'b0;
        set_req(1'b0, 36'd0, 3'd0, 1'b0, 1'b0, 1'b0, 512'd0);
        io_mem_release_ready = 1'b0;
        io_mem_grant_valid = 1'b0;
        io_mem_grant_bits_source = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        settle();
        chk("rst_valid", io_mem_release_valid, 1'b0);
        chk("rst_finish", io_finish, 1'b0);
        reset = 1'b1;
        cycle();

        // Release with two data beats, then ReleaseAck
        d = rnd_data();
        io_mem_release_ready = 1'b1;
        set_req(1'b1, 36'h080001000, 3'd1, 1'b1, 1'b1, 1'b1, d);
        cycle();
        io_req_valid = 1'b0;
        settle();
        chk("t1_valid", io_mem_release_valid, 1'b1);
        chk("t1_opcode", io_mem_release_bits_opcode, 3'd7);
        chk("t1_source", io_mem_release_bits_source, 2'd0);
        chk("t1_beat0", io_mem_release_bits_data, d[255:0]);
        tick();
        settle();
        chk("t1_beat1", io_mem_release_bits_data, d[511:256]);
        tick();
        io_mem_grant_valid = 1'b1;
        io_mem_grant_bits_source = 2'd0;
        settle();
        chk("t1_finish", io_finish, 1'b1);
        chk("t1_finish_id", io_finish_id, 2'd0);
        tick();
        io_mem_grant_valid = 1'b0;

        // Dataless ProbeAck completes on its own fire
        set_req(1'b1, 36'h000ABC040, 3'd3, 1'b0, 1'b0, 1'b0, rnd_data());
        cycle();
        io_req_valid = 1'b0;
        settle();
        chk("t2_opcode", io_mem_release_bits_opcode, 3'd4);
        chk("t2_data", io_mem_release_bits_data, 256'd0);
        chk("t2_param", io_mem_release_bits_param, 3'd3);
        chk("t2_finish", io_finish, 1'b1);
        tick();

        // Two ReleaseData back to back under a toggling ready
        fire_log.delete();
        io_mem_release_ready = 1'b0;
        set_req(1'b1, 36'h000100000, 3'd0, 1'b1, 1'b1, 1'b1, rnd_data());
        cycle();
        for (int k = 0; k < 10; k++) begin
            if (k == 0) set_req(1'b1, 36'h000200000, 3'd1, 1'b1, 1'b1, 1'b0, rnd_data());
            else io_req_valid = 1'b0;
            io_mem_release_ready = (k % 2 == 0);
            cycle();
        end
        chk("t3_beats", fire_log.size(), 4);
        if (fire_log.size() == 4) begin
            chk("t3_order0", fire_log[0], 0);
            chk("t3_order1", fire_log[1], 0);
            chk("t3_order2", fire_log[2], 1);
            chk("t3_order3", fire_log[3], 1);
        end
        drain();

        // Both entries busy, then entry 1 freed by its ReleaseAck
        set_req(1'b1, 36'h000300000, 3'd1, 1'b1, 1'b0, 1'b0, 512'd0);
        cycle();
        set_req(1'b1, 36'h000400000, 3'd1, 1'b1, 1'b0, 1'b0, 512'd0);
        cycle();
        io_req_valid = 1'b0;
        cycle();
        set_req(1'b1, 36'h000500000, 3'd2, 1'b1, 1'b0, 1'b1, 512'd0);
        settle();
        chk("t4_full", io_req_ready, 1'b0);
        tick();
        io_mem_grant_valid = 1'b1;
        io_mem_grant_bits_source = 2'd1;
        settle();
        chk("t4_not_same_cycle", io_req_ready, 1'b0);
        tick();
        io_mem_grant_valid = 1'b0;
        settle();
        chk("t4_ready_next", io_req_ready, 1'b1);
        tick();
        io_req_valid = 1'b0;
        settle();
        chk("t4_alloc_entry1", io_mem_release_bits_source, 2'd1);
        tick();
        drain();

        // Second request to a block still awaiting its ReleaseAck
        set_req(1'b1, 36'h000600040, 3'd1, 1'b1, 1'b0, 1'b1, 512'd0);
        cycle();
        io_req_valid = 1'b0;
        cycle();
        set_req(1'b1, 36'h000600048, 3'd1, 1'b1, 1'b0, 1'b0, 512'd0);
        settle();
`ifdef MULTI_RELEASE_UNIT_ADDR_CHECK_EN
        chk("t5_same_block", io_req_ready, 1'b0);
`else
        chk("t5_same_block", io_req_ready, 1'b1);
`endif
        tick();
`ifndef MULTI_RELEASE_UNIT_ADDR_CHECK_EN
        io_req_valid = 1'b0;
`endif
        io_mem_grant_valid = 1'b1;
        io_mem_grant_bits_source = 2'd0;
        cycle();
        io_mem_grant_valid = 1'b0;
        settle();
        chk("t5_after_grant", io_req_ready, 1'b1);
        tick();
        drain();

        // ProbeAck completion collides with a ReleaseAck
        set_req(1'b1, 36'h000700000, 3'd1, 1'b1, 1'b0, 1'b0, 512'd0);
        cycle();
        set_req(1'b1, 36'h000800000, 3'd2, 1'b0, 1'b0, 1'b0, 512'd0);
        cycle();
        io_req_valid = 1'b0;
        io_mem_grant_valid = 1'b1;
        io_mem_grant_bits_source = 2'd0;
        settle();
        chk("t6_pa_valid", io_mem_release_valid, 1'b1);
        chk("t6_grant_wins", io_finish_id, 2'd0);
        tick();
        io_mem_grant_valid = 1'b0;
        settle();
        chk("t6_deferred", io_finish, 1'b1);
        chk("t6_deferred_id", io_finish_id, 2'd1);
        chk("t6_no_resend", io_mem_release_valid, 1'b0);
        tick();
        settle();
        chk("t6_single_pulse", io_finish, 1'b0);
        tick();

        // Reset during beat 0 drops the message
        set_req(1'b1, 36'h000900000, 3'd1, 1'b1, 1'b1, 1'b1, rnd_data());
        cycle();
        io_req_valid = 1'b0;
        io_mem_release_ready = 1'b0;
        settle();
        chk("t7_beat0", io_mem_release_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("t7_valid_drop", io_mem_release_valid, 1'b0);
        chk("t7_no_finish", io_finish, 1'b0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        io_mem_release_ready = 1'b1;
        repeat (3) cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            a = {$urandom_range(0, 3), 30'h0, 6'h0} | {4'h0, 24'h0, 2'($urandom), 6'($urandom)};
            set_req(1'($urandom), a, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rnd_data());
            io_mem_release_ready = ($urandom_range(0, 3) != 0);
            io_mem_grant_valid = 1'($urandom);
            io_mem_grant_bits_source = SW'($urandom);
            for (int i = 0; i < NE; i++) begin
                if (m_st[i] == ST_WAIT && $urandom_range(0, 1) == 1) io_mem_grant_bits_source = SW'(i);
            end
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
